alu_ctrl_seq: RTL and testbench

//  Next-generation EX-stage ALU control. Decodes ALUOp_i/funct_i into a registered 4-bit ALU control code.

---
 rtl/alu_ctrl_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with an iterative shift-add MUL unit.
// Optional ALU_CTRL_MULHI_EN exposes the upper product half on mul_hi_o.
`default_nettype none

module alu_ctrl_seq #(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [DATA_W-1:0]  data1_i,
  input  logic [DATA_W-1:0]  data2_i,
  output logic               valid_o,
  output logic [3:0]         ALUCtrl_o,
  output logic [DATA_W-1:0]  mul_result_o
`ifdef ALU_CTRL_MULHI_EN
  ,
  output logic [DATA_W-1:0]  mul_hi_o
`endif
);

`ifdef ALU_CTRL_MULHI_EN
  localparam int ACC_W = 2 * DATA_W;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_MUL = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_XOR = FUNCT_W'(6'b100110);
  localparam logic [FUNCT_W-1:0] F_NOR = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101010);

  localparam logic [ALUOP_W-1:0] OP_RTYPE = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(2'b10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   mcand;
  logic [DATA_W-1:0]  mplier;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         code;
  logic               is_mul;
  logic               accept;

  assign ready_o = (state == S_IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;
  assign is_mul  = (ALUOp_i == OP_RTYPE) && (funct_i == F_MUL);

  always_comb begin
    code = 4'b0100;
    if (ALUOp_i == OP_RTYPE) begin
      case (funct_i)
        F_ADD:   code = 4'b0010;
        F_SUB:   code = 4'b0110;
        F_MUL:   code = 4'b0111;
        F_AND:   code = 4'b0000;
        F_OR:    code = 4'b0001;
        F_XOR:   code = 4'b0011;
        F_NOR:   code = 4'b1100;
        F_SLT:   code = 4'b1000;
        default: code = 4'b0100;
      endcase
    end else if (ALUOp_i == OP_OR) begin
      code = 4'b0001;
    end else if (ALUOp_i == OP_ADD) begin
      code = 4'b0010;
    end else begin
      code = 4'b0110;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept && is_mul) next_state = S_MUL;
      S_MUL:   if (cnt == '0) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush_i) next_state = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o      <= 1'b0;
      ALUCtrl_o    <= 4'b0100;
      mul_result_o <= '0;
`ifdef ALU_CTRL_MULHI_EN
      mul_hi_o     <= '0;
`endif
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (is_mul) begin
                mcand  <= ACC_W'(data1_i);
                mplier <= data2_i;
                acc    <= '0;
                cnt    <= CNT_W'(DATA_W - 1);
              end else begin
                ALUCtrl_o <= code;
                valid_o   <= 1'b1;
              end
            end
          end
          S_MUL: begin
            // Fixed DATA_W iterations, even for zero operands, keeps latency constant.
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
          S_DONE: begin
            mul_result_o <= acc[DATA_W-1:0];
`ifdef ALU_CTRL_MULHI_EN
            mul_hi_o     <= acc[ACC_W-1:DATA_W];
`endif
            ALUCtrl_o    <= 4'b0111;
            valid_o      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode vector table plus multi-cycle MUL, flush and reset sequences.
`default_nettype none

module tb_alu_ctrl_seq;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [5:0]        funct_i;
  logic [1:0]        ALUOp_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic              valid_o;
  logic [3:0]        ALUCtrl_o;
  logic [DATA_W-1:0] mul_result_o;
`ifdef ALU_CTRL_MULHI_EN
  logic [DATA_W-1:0] mul_hi_o;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.DATA_W(DATA_W), .FUNCT_W(6), .ALUOP_W(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .funct_i      (funct_i),
    .ALUOp_i      (ALUOp_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .valid_o      (valid_o),
    .ALUCtrl_o    (ALUCtrl_o),
    .mul_result_o (mul_result_o)
`ifdef ALU_CTRL_MULHI_EN
    ,
    .mul_hi_o     (mul_hi_o)
`endif
  );

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int lat = 0;
    int busy_err = 0;
    @(negedge clk);
    valid_i = 1'b1; ALUOp_i = 2'b00; funct_i = 6'b011000; data1_i = a; data2_i = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0; data1_i = '0; data2_i = '0;
    check("mul_ready_low", ready_o, 0);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (valid_o) lat = k;
      else if (ready_o) busy_err++;
    end
    check("mul_latency", lat, 33);
    check("mul_busy_ready", busy_err, 0);
    check("mul_result", mul_result_o, exp_lo);
    check("mul_ctrl", ALUCtrl_o, 4'b0111);
    check("mul_ready_after", ready_o, 1);
`ifdef ALU_CTRL_MULHI_EN
    check("mul_hi", mul_hi_o, exp_hi);
`else
    if (exp_hi != exp_hi) $display("unreachable");
`endif
  endtask

  initial begin
    vecs[0]  = '{2'b00, 6'b100000, 4'b0010};
    vecs[1]  = '{2'b00, 6'b100010, 4'b0110};
    vecs[2]  = '{2'b00, 6'b100100, 4'b0000};
    vecs[3]  = '{2'b00, 6'b100101, 4'b0001};
    vecs[4]  = '{2'b00, 6'b100110, 4'b0011};
    vecs[5]  = '{2'b00, 6'b100111, 4'b1100};
    vecs[6]  = '{2'b00, 6'b101010, 4'b1000};
    vecs[7]  = '{2'b00, 6'b111111, 4'b0100};
    vecs[8]  = '{2'b01, 6'b011000, 4'b0001};
    vecs[9]  = '{2'b10, 6'b011000, 4'b0010};
    vecs[10] = '{2'b11, 6'b011000, 4'b0110};

    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    funct_i = '0; ALUOp_i = '0; data1_i = '0; data2_i = '0;
    #12;
    check("rst_valid", valid_o, 0);
    check("rst_ctrl", ALUCtrl_o, 4'b0100);
    check("rst_mulres", mul_result_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("rst_ready", ready_o, 1);

    // Back-to-back decode, one op per cycle
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      valid_i = 1'b1; ALUOp_i = vecs[i].aluop; funct_i = vecs[i].funct;
      @(posedge clk);
      #1;
      check($sformatf("dec_valid_%0d", i), valid_o, 1);
      check($sformatf("dec_ctrl_%0d", i), ALUCtrl_o, vecs[i].exp);
      check($sformatf("dec_ready_%0d", i), ready_o, 1);
    end
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_no_valid", valid_o, 0);
    check("idle_ctrl_hold", ALUCtrl_o, 4'b0110);

    do_mul(32'd7, 32'd6, 32'd42, 32'd0);
    do_mul(32'd0, 32'd5, 32'd0, 32'd0);
    do_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1);

    // Flush mid-multiply, with a simultaneous valid add that must be dropped
    @(negedge clk);
    valid_i = 1'b1; ALUOp_i = 2'b00; funct_i = 6'b011000; data1_i = 32'd9; data2_i = 32'd9;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; funct_i = 6'b100000;
    @(posedge clk);
    #1;
    check("flush_ready", ready_o, 1);
    check("flush_valid", valid_o, 0);
    check("flush_mulres", mul_result_o, 32'hFFFFFFFE);
    check("flush_ctrl", ALUCtrl_o, 4'b0111);
    @(negedge clk);
    flush_i = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("post_flush_add_valid", valid_o, 1);
    check("post_flush_add_ctrl", ALUCtrl_o, 4'b0010);
    begin
      int stray = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (valid_o) stray++;
      end
      check("flush_no_stray_valid", stray, 0);
      check("flush_mulres_hold", mul_result_o, 32'hFFFFFFFE);
    end

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    valid_i = 1'b1; ALUOp_i = 2'b00; funct_i = 6'b011000; data1_i = 32'd4; data2_i = 32'd4;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_ctrl", ALUCtrl_o, 4'b0100);
    check("arst_mulres", mul_result_o, 0);
    check("arst_ready", ready_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    do_mul(32'd3, 32'd5, 32'd15, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
